ecall_write_streamer: RTL and testbench

- Parametrised successor to the single-channel write-ecall byte sender.
- On a CPU write ecall, fetches `len` bytes starting at `addr` from word-wide data memory and streams them one byte at a time over a valid/ready output port.
- The fd selects which output channel is used; `done` is the `write_ecall_finished` handshake back to the CPU.
- Sits between the CPU ecall signals, the data-memory read mux and the external IO pins.

---
 rtl/ecall_write_streamer.sv | 114 +++++++++++
 tb/tb_ecall_write_streamer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ecall_write_streamer.sv
// ecall_write_streamer: streams req_len bytes from word memory to the fd-selected channel (STREAM_CHECKSUM_EN adds a checksum trailer byte)
module ecall_write_streamer #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int LEN_WIDTH    = 16,
  parameter int NUM_CHANNELS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic [31:0]             req_fd,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LEN_WIDTH-1:0]    req_len,
  output logic                    done,
  output logic                    busy,
  output logic                    err_bad_fd,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CHANNELS-1:0] out_chan
);
  localparam int LANE = $clog2(DATA_WIDTH / 8);
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, FINISH} state_t;
  state_t state, state_nx;
  logic armed, bad, accept, fire, fd_ok, last, tail;
  logic [ADDR_WIDTH-1:0] cur_addr, nxt_addr;
  logic [LEN_WIDTH-1:0] remaining;
  logic [CW-1:0] chan;
  logic [DATA_WIDTH-1:0] word_buf;
  logic [7:0] lane_byte, byte_out;
  assign fd_ok = req_fd != 32'd0 && req_fd <= 32'(NUM_CHANNELS);
  assign accept = state == IDLE && req && armed;
  assign fire = out_valid && out_ready;
  assign nxt_addr = cur_addr + 1'b1;
  assign last = remaining == LEN_WIDTH'(1);
  assign lane_byte = 8'(word_buf >> {cur_addr[LANE-1:0], 3'b000});
`ifdef STREAM_CHECKSUM_EN
  localparam state_t EMPTY_ST = SEND;
  logic trl;
  logic [7:0] sum;
  // trailer flag and running modulo-256 payload sum
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      trl <= 1'b0;
      sum <= 8'd0;
    end else if (accept) begin
      trl <= req_len == '0;
      sum <= 8'd0;
    end else if (fire && !trl) begin
      trl <= last;
      sum <= sum + lane_byte;
    end
  assign byte_out = trl ? 8'(~sum + 8'd1) : lane_byte;
  assign tail = trl;
`else
  localparam state_t EMPTY_ST = FINISH;
  assign byte_out = lane_byte;
  assign tail = last;
`endif
  // state register and request re-arm guard
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= accept ? 1'b0 : (armed || !req);
    end
  // request latch, byte walk and word buffer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      chan      <= '0;
      bad       <= 1'b0;
      word_buf  <= '0;
    end else begin
      if (accept) begin
        cur_addr  <= req_addr;
        remaining <= req_len;
        chan      <= CW'(req_fd - 32'd1);
        bad       <= !fd_ok;
      end else if (fire) begin
        cur_addr  <= nxt_addr;
        remaining <= remaining - 1'b1;
      end
      if (state == WAIT) word_buf <= mem_rdata;
    end
  // next-state: fetch a word, then drain it until the count or the word runs out
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !accept ? IDLE : !fd_ok ? FINISH : req_len != '0 ? FETCH : EMPTY_ST;
      FETCH:   state_nx = WAIT;
      WAIT:    state_nx = SEND;
      SEND:    state_nx = !fire ? SEND : tail ? FINISH :
                          (last || nxt_addr[LANE-1:0] != '0) ? SEND : FETCH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign done       = state == IDLE || state == FINISH;
  assign busy       = !done;
  assign err_bad_fd = state == FINISH && bad;
  assign mem_rd_en  = state == FETCH;
  assign mem_addr   = mem_rd_en ? {cur_addr[ADDR_WIDTH-1:LANE], {LANE{1'b0}}} : '0;
  assign out_valid  = state == SEND;
  assign out_data   = out_valid ? byte_out : 8'd0;
  assign out_chan   = out_valid ? NUM_CHANNELS'(1) << chan : '0;
endmodule

// File: tb/tb_ecall_write_streamer.sv
// tb_ecall_write_streamer: table-driven scoreboard bench for ecall_write_streamer (honours STREAM_CHECKSUM_EN)
module tb_ecall_write_streamer;
  logic clk = 0, rst = 1, req = 0, out_ready = 1;
  logic [31:0] req_fd = 0, req_addr = 0, mem_addr, mem_rdata = 0;
  logic [15:0] req_len = 0;
  logic done, busy, err_bad_fd, mem_rd_en, out_valid;
  logic [7:0] out_data;
  logic [1:0] out_chan;
  int compared = 0, mismatched = 0;
  int hs_cnt = 0, rd_cnt = 0, err_cnt = 0, busy_cnt = 0, mode = 0;
  logic [31:0] mem [0:255];
  logic [9:0] q [$];
  logic [31:0] aq [$];
  logic prev_stall = 0;
  logic [9:0] prev_out = 0;
  typedef struct {
    logic [31:0] fd, addr;
    logic [15:0] len;
    int mode, hold, exp_n, exp_err;
  } vec_t;
  vec_t tbl [9];

  ecall_write_streamer dut (
    .clk(clk), .rst(rst), .req(req), .req_fd(req_fd), .req_addr(req_addr), .req_len(req_len),
    .done(done), .busy(busy), .err_bad_fd(err_bad_fd), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr[9:2]] : 32'hDEADBEEF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %0s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mb(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return w[8*a[1:0] +: 8];
  endfunction

  initial forever begin
    @(posedge clk);
    #1 out_ready = mode == 0 ? 1'b1 : mode == 1 ? ~out_ready : 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (rst) prev_stall <= 0;
    else begin
      if (prev_stall) chk("stall_hold", {out_valid, out_chan, out_data}, {1'b1, prev_out});
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_byte: got %0h expected none", out_data);
        end else chk("byte", {out_chan, out_data}, q.pop_front());
      end
      if (mem_rd_en) begin
        rd_cnt++;
        if (aq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_read: got %0h expected none", mem_addr);
        end else chk("mem_addr", mem_addr, aq.pop_front());
      end
      if (err_bad_fd) err_cnt++;
      if (busy) busy_cnt++;
      prev_stall <= out_valid && !out_ready;
      prev_out <= {out_chan, out_data};
    end
  end

  task automatic check_reset_outputs();
    chk("rst_outs", {done, busy, err_bad_fd, mem_rd_en, out_valid}, 5'b10000);
    chk("rst_data", {mem_addr, out_data, out_chan}, 42'd0);
  endtask

  task automatic xfer(input vec_t v);
    logic [7:0] s, b;
    logic [1:0] ch;
    int words, ck;
    bit ok;
    s = 0;
    ch = 2'(1 << (v.fd - 1));
    words = v.exp_n == 0 ? 0 : (int'(v.addr[1:0]) + v.exp_n + 3) / 4;
    ck = 0;
    for (int i = 0; i < v.exp_n; i++) begin
      b = mb(v.addr + 32'(i));
      s += b;
      q.push_back({ch, b});
    end
    for (int k = 0; k < words; k++) aq.push_back({v.addr[31:2], 2'b00} + 32'(4 * k));
`ifdef STREAM_CHECKSUM_EN
    if (v.exp_err == 0) begin
      q.push_back({ch, 8'(~s + 8'd1)});
      ck = 1;
    end
`endif
    @(posedge clk);
    #1 req = 0;
    mode = v.mode;
    @(posedge clk);
    #1 req = 1;
    req_fd = v.fd;
    req_addr = v.addr;
    req_len = v.len;
    rd_cnt = 0;
    err_cnt = 0;
    busy_cnt = 0;
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == 4) begin
        req_fd = 32'd7;
        req_addr = ~req_addr;
        req_len = 16'd3;
      end
      if (c >= 2 && done && q.size() == 0 && aq.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: got %0d bytes pending expected 0", q.size());
    end
    repeat (3 + v.hold) @(negedge clk);
    chk("reads", rd_cnt, words);
    chk("err_pulses", err_cnt, v.exp_err);
    if (v.mode == 0) chk("busy_cycles", busy_cnt, 2 * words + v.exp_n + ck);
    q.delete();
    aq.delete();
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h40] = 32'h44332211;
    mem[8'h41] = 32'h88776655;
    //        fd     addr          len  mode hold n  err
    tbl[0] = '{32'd1, 32'h100,      16'd4, 0, 0,  4, 0};
    tbl[1] = '{32'd1, 32'h102,      16'd4, 1, 0,  4, 0};
    tbl[2] = '{32'd1, 32'h100,      16'd0, 0, 0,  0, 0};
    tbl[3] = '{32'd3, 32'h100,      16'd4, 0, 0,  0, 1};
    tbl[4] = '{32'd0, 32'h100,      16'd4, 0, 0,  0, 1};
    tbl[5] = '{32'd2, 32'h103,      16'd9, 2, 0,  9, 0};
    tbl[6] = '{32'd1, 32'h100,      16'd4, 0, 20, 4, 0};
    tbl[7] = '{32'd2, 32'hFFFFFFFE, 16'd4, 0, 0,  4, 0};
    tbl[8] = '{32'd2, 32'h1FD,      16'd7, 1, 0,  7, 0};
    repeat (3) @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 9; i++) xfer(tbl[i]);
    for (int i = 0; i < 8; i++) q.push_back({2'b01, mb(32'h100 + 32'(i))});
    aq.push_back(32'h100);
    aq.push_back(32'h104);
    mode = 0;
    @(posedge clk);
    #1 req = 0;
    @(posedge clk);
    #1 req = 1;
    req_fd = 1;
    req_addr = 32'h100;
    req_len = 16'd8;
    hs_cnt = 0;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (hs_cnt == 2) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL mid_reset_wait: got %0d bytes expected 2", hs_cnt);
    end
    chk("pre_reset_valid", out_valid, 1'b1);
    #2 rst = 1;
    #1 check_reset_outputs();
    q.delete();
    aq.delete();
    req = 0;
    @(posedge clk);
    #1 rst = 0;
    xfer(tbl[0]);
    xfer(tbl[5]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
